// File: rtl/plane_fetch_engine_pkg.sv
// Shared types, default geometry and width helpers for the planar fetch engine.
package plane_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_ADDR_W       = 17;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_BPC          = 4;
  localparam int unsigned DEF_NUM_CH       = 3;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_PLANE_WORDS  = 38400;
  localparam int unsigned DEF_PLANE_STRIDE = 38400;
  localparam int unsigned PIX_PER_WORD     = DEF_DATA_W / DEF_BPC;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plane_fetch_engine_word_fifo.sv
// Single-channel word FIFO; pushes and pops in the same cycle keep occupancy.
module plane_word_fifo
  import plane_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/plane_fetch_engine.sv
// Round-robin planar framebuffer fetch with per-channel word FIFOs and pixel unpack.
// Optional underrun counter is built when UNDERRUN_CNT_EN is defined.
module plane_fetch_engine
  import plane_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned BPC          = DEF_BPC,
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned PLANE_WORDS  = DEF_PLANE_WORDS,
  parameter int unsigned PLANE_STRIDE = DEF_PLANE_STRIDE
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  en_fetching,
  input  logic                  restart,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_rtr,
  input  logic                  mem_rts,
  output logic [NUM_CH*BPC-1:0] out_data,
  output logic                  out_rts,
  input  logic                  out_rtr,
  output logic                  frame_done,
  output logic [15:0]           underrun_cnt
);

  localparam int unsigned PPW       = DATA_W / BPC;
  localparam int unsigned IDX_W     = idx_w(PPW);
  localparam int unsigned CH_W      = idx_w(NUM_CH);
  localparam int unsigned WP_W      = idx_w(PLANE_WORDS);
  localparam int unsigned FRAME_PIX = PLANE_WORDS * PPW;
  localparam int unsigned PC_W      = idx_w(FRAME_PIX);
  localparam int unsigned OUT_W     = NUM_CH * BPC;

  logic              clear;
  arb_state_t        state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_found;
  logic [ADDR_W-1:0] sel_addr;
  logic [WP_W-1:0]   word_ptr [NUM_CH];
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] push_vec;
  logic [DATA_W-1:0] head [NUM_CH];
  logic [OUT_W-1:0]  pixel_raw;
  logic [IDX_W-1:0]  pix_idx;
  logic [PC_W-1:0]   pix_cnt;
  logic              push_en;
  logic              xfer;
  logic              idx_last;
  logic              pop_all;

  // Restart and fetch-disable share the reset path and win over any transfer.
  assign clear = rst_ | restart | ~en_fetching;

  // First non-full channel at or after the round-robin pointer.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (32'(rr_ptr) + i) % NUM_CH;
      if (!sel_found && !fifo_full[CH_W'(cand)]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(cand);
      end
    end
    sel_addr = ADDR_W'((32'(sel_ch) * 32'(PLANE_STRIDE)) + 32'(word_ptr[sel_ch]));
  end

  // Address and request are latched on entry to REQ and held until accepted.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_ch   <= '0;
      mem_rtr  <= 1'b0;
      mem_addr <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        word_ptr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            cur_ch   <= sel_ch;
            mem_addr <= sel_addr;
            mem_rtr  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_rts) begin
            word_ptr[cur_ch] <= (word_ptr[cur_ch] == WP_W'(PLANE_WORDS - 1)) ?
                                '0 : word_ptr[cur_ch] + WP_W'(1);
            rr_ptr  <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
            mem_rtr <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  assign push_en = mem_rtr & mem_rts;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    assign push_vec[g] = push_en && (cur_ch == CH_W'(g));

    plane_word_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (clear),
      .push      (push_vec[g]),
      .pop       (pop_all),
      .push_data (mem_data),
      .head      (head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );

    // Channel 0 lands in the most-significant field; LSB field of a word goes first.
    assign pixel_raw[(int'(NUM_CH) - 1 - g) * int'(BPC) +: BPC] =
      BPC'(head[g] >> (32'(pix_idx) * BPC));
  end

  assign out_rts  = ~|fifo_empty;
  assign out_data = out_rts ? pixel_raw : '0;
  assign xfer     = out_rts & out_rtr;
  assign idx_last = (pix_idx == IDX_W'(PPW - 1));
  assign pop_all  = xfer & idx_last;

  always_ff @(posedge clk) begin
    if (clear) begin
      pix_idx    <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && (pix_cnt == PC_W'(FRAME_PIX - 1));
      if (xfer) begin
        pix_idx <= idx_last ? '0 : pix_idx + IDX_W'(1);
        pix_cnt <= (pix_cnt == PC_W'(FRAME_PIX - 1)) ? '0 : pix_cnt + PC_W'(1);
      end
    end
  end

`ifdef UNDERRUN_CNT_EN
  // Cycles where the display wanted a pixel and none was ready; saturating.
  always_ff @(posedge clk) begin
    if (clear) begin
      underrun_cnt <= '0;
    end else if (out_rtr && !out_rts && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_plane_fetch_engine.sv
// Directed bench for plane_fetch_engine: default geometry plus a two-word-plane instance for frame wrap.
module tb_plane_fetch_engine;

  typedef struct {
    logic [16:0] exp_addr;
    logic [11:0] exp_pix;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_;
  logic        en_fetching;
  logic        restart;
  logic [16:0] mem_addr, mem_addr2;
  logic [31:0] mem_data, mem_data2;
  logic        mem_rtr, mem_rts, mem_rtr2, mem_rts2;
  logic [11:0] out_data, out_data2;
  logic        out_rts, out_rtr, out_rts2, out_rtr2;
  logic        frame_done, frame_done2;
  logic [15:0] underrun_cnt, underrun_cnt2;

  always #5 clk = ~clk;

  // Memory model: each word holds its own address.
  assign mem_data  = 32'(mem_addr);
  assign mem_data2 = 32'(mem_addr2);

  plane_fetch_engine dut (
    .clk          (clk),
    .rst_         (rst_),
    .en_fetching  (en_fetching),
    .restart      (restart),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_rtr      (mem_rtr),
    .mem_rts      (mem_rts),
    .out_data     (out_data),
    .out_rts      (out_rts),
    .out_rtr      (out_rtr),
    .frame_done   (frame_done),
    .underrun_cnt (underrun_cnt)
  );

  plane_fetch_engine #(.PLANE_WORDS(2)) dut2 (
    .clk          (clk),
    .rst_         (rst_),
    .en_fetching  (en_fetching),
    .restart      (restart),
    .mem_addr     (mem_addr2),
    .mem_data     (mem_data2),
    .mem_rtr      (mem_rtr2),
    .mem_rts      (mem_rts2),
    .out_data     (out_data2),
    .out_rts      (out_rts2),
    .out_rtr      (out_rtr2),
    .frame_done   (frame_done2),
    .underrun_cnt (underrun_cnt2)
  );

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  vec_t        vec [13];
  logic [16:0] addr_q [$];
  logic [16:0] addr2_q [$];
  logic [11:0] pix_q [$];
  int unsigned px2_cnt = 0;
  int unsigned fd2_cnt = 0;
  int unsigned fd2_at  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_tables(input string tag);
    for (int i = 0; i < 13; i++) begin
      logic [16:0] a;
      logic [11:0] p;
      a = (i < addr_q.size()) ? addr_q[i] : 17'h1FFFF;
      p = (i < pix_q.size()) ? pix_q[i] : 12'hFFF;
      chk($sformatf("%s_addr%0d", tag, i), 32'(a), 32'(vec[i].exp_addr));
      chk($sformatf("%s_pix%0d", tag, i), 32'(p), 32'(vec[i].exp_pix));
    end
  endtask

  // Transaction monitor, sampled mid-cycle; cleared cycles carry no transfers.
  always @(negedge clk) begin
    if (!rst_ && en_fetching && !restart) begin
      if (mem_rtr && mem_rts)   addr_q.push_back(mem_addr);
      if (out_rts && out_rtr)   pix_q.push_back(out_data);
      if (mem_rtr2 && mem_rts2) addr2_q.push_back(mem_addr2);
      if (out_rts2 && out_rtr2) px2_cnt++;
      if (frame_done2) begin
        fd2_cnt++;
        fd2_at = px2_cnt;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned t;
    int unsigned bad;

    vec[0]  = '{17'd0,     12'h000};
    vec[1]  = '{17'd38400, 12'h000};
    vec[2]  = '{17'd76800, 12'h06C};
    vec[3]  = '{17'd1,     12'h092};
    vec[4]  = '{17'd38401, 12'h001};
    vec[5]  = '{17'd76801, 12'h000};
    vec[6]  = '{17'd2,     12'h000};
    vec[7]  = '{17'd38402, 12'h000};
    vec[8]  = '{17'd76802, 12'h111};
    vec[9]  = '{17'd3,     12'h000};
    vec[10] = '{17'd38403, 12'h06C};
    vec[11] = '{17'd76803, 12'h092};
    vec[12] = '{17'd4,     12'h001};

    rst_ = 1'b1; en_fetching = 1'b1; restart = 1'b0;
    mem_rts = 1'b0; out_rtr = 1'b0; mem_rts2 = 1'b0; out_rtr2 = 1'b0;
    cyc(3);
    chk("rst_mem_rtr", 32'(mem_rtr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_out_rts", 32'(out_rts), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun_cnt), 0);

    // Streaming from reset release.
    mem_rts = 1'b1; out_rtr = 1'b1; rst_ = 1'b0;
    lat = 0;
    while (!out_rts && lat < 20) begin cyc(1); lat++; end
    chk("first_pixel_latency_ok", 32'(lat > 0 && lat <= 7), 1);
    cyc(100);
    check_tables("stream");

    // Backpressure: stall after two pixels, FIFOs must fill and hold.
    restart = 1'b1; cyc(1); restart = 1'b0;
    addr_q.delete(); pix_q.delete();
    t = 0;
    while (pix_q.size() < 2 && t < 40) begin cyc(1); t++; end
    out_rtr = 1'b0;
    bad = 0;
    repeat (50) begin cyc(1); if (out_data !== 12'h06C) bad++; end
    chk("stall_out_data_stable", bad, 0);
    chk("stall_out_rts", 32'(out_rts), 1);
    chk("stall_mem_rtr", 32'(mem_rtr), 0);
    chk("stall_words_fetched", addr_q.size(), 12);
    out_rtr = 1'b1;
    cyc(100);
    check_tables("resume");

    // Memory not ready: request and address must hold.
    restart = 1'b1; out_rtr = 1'b0; cyc(1); restart = 1'b0;
    addr_q.delete();
    t = 0;
    while (addr_q.size() < 4 && t < 40) begin cyc(1); t++; end
    mem_rts = 1'b0;
    bad = 0;
    repeat (10) begin cyc(1); if (!(mem_rtr === 1'b1 && mem_addr === 17'd38401)) bad++; end
    chk("hold_req_addr", bad, 0);
    chk("hold_no_push", addr_q.size(), 4);
    mem_rts = 1'b1;
    cyc(2);
    chk("hold_release_addr", 32'((addr_q.size() > 4) ? addr_q[4] : 17'h1FFFF), 38401);

    // Restart landing on an accepted memory transfer.
    out_rtr = 1'b1;
    cyc(40);
    t = 0;
    while (!mem_rtr && t < 10) begin cyc(1); t++; end
    chk("restart_setup_req", 32'(mem_rtr), 1);
    restart = 1'b1; cyc(1); restart = 1'b0;
    addr_q.delete();
    chk("restart_mem_rtr", 32'(mem_rtr), 0);
    chk("restart_mem_addr", 32'(mem_addr), 0);
    chk("restart_out_rts", 32'(out_rts), 0);
    chk("restart_out_data", 32'(out_data), 0);
    chk("restart_frame_done", 32'(frame_done), 0);
    cyc(10);
    chk("restart_first_addr", 32'((addr_q.size() > 0) ? addr_q[0] : 17'h1FFFF), 0);
    chk("restart_second_addr", 32'((addr_q.size() > 1) ? addr_q[1] : 17'h1FFFF), 38400);

    // Fetch disable for one cycle acts as a clear.
    cyc(20);
    chk("pre_disable_out_rts", 32'(out_rts), 1);
    en_fetching = 1'b0; cyc(1);
    chk("disable_mem_rtr", 32'(mem_rtr), 0);
    chk("disable_out_rts", 32'(out_rts), 0);
    chk("disable_out_data", 32'(out_data), 0);
    en_fetching = 1'b1;

    // Two-word planes: one frame is 16 pixels.
    addr2_q.delete(); px2_cnt = 0; fd2_cnt = 0; fd2_at = 0;
    mem_rts2 = 1'b1; out_rtr2 = 1'b1;
    t = 0;
    while (px2_cnt < 16 && t < 200) begin cyc(1); t++; end
    out_rtr2 = 1'b0;
    cyc(10);
    chk("frame_pixels", px2_cnt, 16);
    chk("frame_done_pulses", fd2_cnt, 1);
    chk("frame_done_after_pixel", fd2_at, 16);
    chk("wrap_addr3", 32'((addr2_q.size() > 3) ? addr2_q[3] : 17'h1FFFF), 1);
    chk("wrap_addr6", 32'((addr2_q.size() > 6) ? addr2_q[6] : 17'h1FFFF), 0);
    chk("wrap_addr7", 32'((addr2_q.size() > 7) ? addr2_q[7] : 17'h1FFFF), 38400);
    chk("wrap_addr8", 32'((addr2_q.size() > 8) ? addr2_q[8] : 17'h1FFFF), 76800);

    // Underrun: memory starved, display always ready.
    mem_rts = 1'b0; out_rtr = 1'b1;
    restart = 1'b1; cyc(1); restart = 1'b0;
    cyc(100);
`ifdef UNDERRUN_CNT_EN
    chk("underrun_100", 32'(underrun_cnt), 100);
    cyc(69900);
    chk("underrun_saturate", 32'(underrun_cnt), 32'h0000FFFF);
`else
    chk("underrun_100", 32'(underrun_cnt), 0);
    cyc(200);
    chk("underrun_disabled", 32'(underrun_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/plane_fetch_engine.md
Name: plane_fetch_engine

Overview:
- Parametrised successor of the three-plane RGB fetch path.
- Fetches 32-bit words from NUM_CH planar framebuffers in round-robin order and buffers them in per-channel word FIFOs.
- Unpacks BPC-bit fields and emits one NUM_CH*BPC-bit pixel per handshake to the display timing stage.
- Adds configurable depth and width, frame wrap with a frame_done pulse, and a synchronous restart.

Parameters:
- ADDR_W, 17, memory address width.
- DATA_W, 32, memory word width.
- BPC, 4, bits per channel per pixel; DATA_W/BPC must be a power of two.
- NUM_CH, 3, number of colour planes; channel 0 is the most-significant field of out_data.
- FIFO_DEPTH, 4, words buffered per channel; power of two, at least 2.
- PLANE_WORDS, 38400, words per plane per frame (640x480 at BPC 4).
- PLANE_STRIDE, 38400, address distance between plane bases.

Ports:
- clk  in  1  sole clock.
- rst_  in  1  reset: synchronous, active-high.
- en_fetching  in  1  when low, behaves as restart: pointers, FIFOs and unpackers are cleared.
- restart  in  1  one-cycle pulse; synchronous frame restart, same effect as reset.
- mem_addr  out  ADDR_W  word address of the current request.
- mem_data  in  DATA_W  read data for mem_addr, same cycle.
- mem_rtr  out  1  engine requests/accepts a word.
- mem_rts  in  1  memory has valid data.
- out_data  out  NUM_CH*BPC  current pixel.
- out_rts  out  1  pixel valid.
- out_rtr  in  1  display accepts the pixel (active video).
- frame_done  out  1  one-cycle pulse when the last pixel of the frame transfers.
- underrun_cnt  out  16  see Optional Feature.

Behaviour:
- Reset, restart, or en_fetching low (checked every clk edge): mem_rtr=0, mem_addr=0, out_rts=0, out_data=0, frame_done=0. Fetch channel ptr=0, all word ptrs=0, FIFOs empty, unpack index=0. Restart has priority over any transfer in the same cycle.
- Fetch arbiter, states IDLE, REQ:
  - IDLE: select the lowest-numbered channel at or after rr_ptr whose FIFO is not full; go to REQ.
  - REQ: mem_rtr=1; mem_addr=(ch*PLANE_STRIDE+word_ptr[ch]) truncated to ADDR_W.
  - On mem_rtr&mem_rts: push mem_data into FIFO[ch]; word_ptr[ch] increments, wrapping PLANE_WORDS-1 -> 0; rr_ptr=ch+1 mod NUM_CH; return to IDLE.
  - mem_rtr is held with a stable mem_addr until the transfer; at most one transfer per 2 cycles.
- Unpacker, per channel: the head word is consumed LSB field first. Field k is data[k*BPC +: BPC], k = 0..DATA_W/BPC-1.
- out_rts=1 iff every channel FIFO is non-empty. Latency: first out_rts at most 2*NUM_CH+1 cycles after release with mem_rts tied 1.
- out_data={field(ch0),...,field(chN-1)}; combinational from FIFO heads and the shared unpack index.
- On out_rts&out_rtr: index increments. Wrap to 0 pops every FIFO head in the same cycle.
- A push to a full FIFO never occurs; the arbiter skips full FIFOs. A push and pop of the same FIFO in one cycle is legal; occupancy is unchanged.
- Pixel counter counts transfers, wrapping PLANE_WORDS*(DATA_W/BPC)-1 -> 0. frame_done=1 in the cycle after the wrapping transfer.
- out_data is stable while out_rts=1 and out_rtr=0.

Optional Feature:
- UNDERRUN_CNT_EN defined: underrun_cnt increments each cycle with out_rtr=1 and out_rts=0; saturates at 16'hFFFF; cleared by reset/restart/en_fetching low.
- Not defined: underrun_cnt tied to 0; no counter logic.

Decomposition:
- Package plane_fetch_pkg: arbiter state enum (IDLE, REQ), PIX_PER_WORD=DATA_W/BPC, index width function, default geometry constants.
- Sub-module plane_word_fifo: single-channel FIFO_DEPTH x DATA_W, push/pop/full/empty/head. Instantiated NUM_CH times in a generate loop.

Test Plan:
- Defaults, mem_rts=1, mem_data=address, out_rtr=1 -> request order 0, 38400, 76800, 1, 38401, ...; first pixel {0,0,0}, second {0x0,0x0,0x0}, ninth {1,1,1} (low nibbles of addresses 1, 38401, 76801).
- out_rtr=0 for 50 cycles after start -> every FIFO holds 4 words, mem_rtr=0, out_data stable; resume -> no pixel lost.
- mem_rts held 0 for 10 cycles in REQ -> mem_addr unchanged, no push.
- PLANE_WORDS=2, 16 pixels pulled -> frame_done pulses once; the next request address wraps to word 0 of each plane.
- Restart pulse mid-frame coincident with a memory transfer -> next cycle all outputs at reset values; the fetch restarts at address 0.
- UNDERRUN_CNT_EN, mem_rts=0, out_rtr=1 for 70000 cycles -> underrun_cnt=16'hFFFF; without the macro -> 0.
